// File: rtl/jtag_mem_loader.sv
// jtag_mem_loader: core-clock consumer of the BSCANE2 byte receiver.
// Synchronises the receiver strobes, acknowledges each byte with a
// four-phase level handshake, packs bytes little-endian into 32-bit words
// and writes them to instruction memory from word address 0 upwards.
//
// Handshake (receiver <-> loader): the receiver raises word_rdy_i with
// data_i stable; the loader captures data_i once word_rdy_i is seen high and
// raises ack_o; the receiver drops word_rdy_i; the loader drops ack_o once it
// sees word_rdy_i low. Only then may the next byte be offered.
module jtag_mem_loader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int BYTE_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sel_i,
    input  logic                  jtag_reset_i,
    input  logic                  word_rdy_i,
    input  logic [BYTE_WIDTH-1:0] data_i,
    output logic                  ack_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  core_rst_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT_LOW,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sel_sync_q, jrst_sync_q, rdy_sync_q;
    logic                    sel_s, jrst_s, rdy_s;
    logic                    ack_q, ack_d;
    logic                    we_q, we_d;
    logic                    done_q, done_d;
    logic                    core_rst_q, core_rst_d;
    logic                    ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic [31:0]             out_data_q, out_data_d;
    logic [31:0]             word_q, word_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    do_write;

    assign sel_s  = sel_sync_q[SYNC_STAGES-1];
    assign jrst_s = jrst_sync_q[SYNC_STAGES-1];
    assign rdy_s  = rdy_sync_q[SYNC_STAGES-1];

    // Multi-flop synchronisers for the TCK-domain control strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_sync_q  <= '0;
            jrst_sync_q <= '0;
            rdy_sync_q  <= '0;
        end else begin
            sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_i};
            jrst_sync_q <= {jrst_sync_q[SYNC_STAGES-2:0], jtag_reset_i};
            rdy_sync_q  <= {rdy_sync_q[SYNC_STAGES-2:0], word_rdy_i};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b0;
            ovf_q      <= 1'b0;
            addr_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            we_q       <= we_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            ovf_q      <= ovf_d;
            addr_q     <= addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: handshake sequencing, byte packing and word writes.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        core_rst_d = core_rst_q;
        ovf_d      = ovf_q;
        addr_d     = addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        do_write   = 1'b0;

        if (state_q != S_IDLE && jrst_s) begin
            // Receiver reset aborts the session; overflow is kept for inspection.
            state_d    = S_IDLE;
            ack_d      = 1'b0;
            cnt_d      = '0;
            word_d     = '0;
            core_rst_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Gated by jrst_s so a held receiver reset cannot restart a session.
                    if (sel_s && !jrst_s) begin
                        state_d    = S_ACTIVE;
                        core_rst_d = 1'b1;
                        addr_d     = '0;
                        cnt_d      = '0;
                        word_d     = '0;
                        ovf_d      = 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (rdy_s) begin
                        // data_i is stable whenever the synchronised ready is high.
                        case (cnt_q)
                            2'd0:    word_d[7:0]   = data_i;
                            2'd1:    word_d[15:8]  = data_i;
                            2'd2:    word_d[23:16] = data_i;
                            default: word_d[31:24] = data_i;
                        endcase
                        ack_d   = 1'b1;
                        state_d = S_WAIT_LOW;
                    end else if (!sel_s) begin
                        state_d = S_FLUSH;
                    end
                end
                S_WAIT_LOW: begin
                    if (!rdy_s) begin
                        ack_d = 1'b0;
                        if (cnt_q == 2'd3) begin
                            cnt_d   = '0;
                            state_d = S_WRITE;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = S_ACTIVE;
                        end
                    end
                end
                S_WRITE: begin
                    do_write = 1'b1;
                    state_d  = S_ACTIVE;
                end
                S_FLUSH: begin
                    // Upper lanes of a partial word are already zero.
                    do_write = (cnt_q != 2'd0);
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    done_d     = 1'b1;
                    core_rst_d = 1'b0;
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_write) begin
            we_d       = 1'b1;
            out_addr_d = addr_q;
            out_data_d = word_q;
            addr_d     = addr_q + 1'b1;
            word_d     = '0;
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign ack_o      = ack_q;
    assign mem_we_o   = we_q;
    assign mem_addr_o = out_addr_q;
    assign mem_data_o = out_data_q;
    assign core_rst_o = core_rst_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_jtag_mem_loader.sv
// Bench for jtag_mem_loader: acts as the JTAG byte receiver, predicts the
// memory image from the byte stream and checks every write and idle cycle.
module tb_jtag_mem_loader;

    localparam int AW    = 2;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] byte_q_t[$];

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          sel_i = 1'b0;
    logic          jtag_reset_i = 1'b0;
    logic          word_rdy_i = 1'b0;
    logic [7:0]    data_i = 8'h00;
    logic          ack_o, mem_we_o, core_rst_o, done_o, overflow_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;

    always #5 clk = ~clk;

    jtag_mem_loader #(
        .ADDR_WIDTH (AW),
        .BYTE_WIDTH (8),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sel_i       (sel_i),
        .jtag_reset_i(jtag_reset_i),
        .word_rdy_i  (word_rdy_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .core_rst_o  (core_rst_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [AW+31:0]  exp_q[$];
    logic [AW+31:0]  wr_log[$];
    int              done_cnt = 0;
    int              start_done = 0;
    logic            exp_ovf = 1'b0;
    logic [AW-1:0]   last_addr = '0;
    logic [31:0]     last_data = '0;
    logic            prev_we = 1'b0;
    logic            prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Compare process: every write against the predicted image, idle outputs hold.
    always @(negedge clk) begin
        if (rst_i) begin
            last_addr = '0;
            last_data = '0;
            prev_we   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (mem_we_o) begin
                wr_log.push_back({mem_addr_o, mem_data_o});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                             mem_addr_o, mem_data_o);
                    last_addr = mem_addr_o;
                    last_data = mem_data_o;
                end else begin
                    logic [AW+31:0] e;
                    e = exp_q.pop_front();
                    check("write_addr_data", {mem_addr_o, mem_data_o}, e);
                    last_addr = e[AW+31:32];
                    last_data = e[31:0];
                end
                check("we_one_cycle", prev_we, 1'b0);
            end else begin
                check("hold_addr", mem_addr_o, last_addr);
                check("hold_data", mem_data_o, last_data);
            end
            if (done_o) begin
                done_cnt++;
                check("done_one_cycle", prev_done, 1'b0);
                check("done_after_writes", exp_q.size(), 0);
                check("core_rst_at_done", core_rst_o, 1'b0);
            end
            prev_we   = mem_we_o;
            prev_done = done_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n;
        n = 0;
        while (ack_o !== lvl && n < 30) begin
            tick(1);
            n++;
        end
        check(name, ack_o, lvl);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        data_i     = b;
        word_rdy_i = 1'b1;
        wait_ack(1'b1, "ack_rise");
        check("core_rst_in_session", core_rst_o, 1'b1);
        tick(hold);
        word_rdy_i = 1'b0;
        wait_ack(1'b0, "ack_fall");
        tick($urandom_range(0, 3));
    endtask

    // Predict the memory image: little-endian words from address 0, wrapping
    // at DEPTH; a trailing partial word is written only on a clean session end.
    task automatic session_begin(input byte_q_t b, input bit abort);
        int          n_words;
        logic [31:0] w;
        n_words = abort ? (b.size() / 4) : ((b.size() + 3) / 4);
        for (int i = 0; i < n_words; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < b.size()) w[8*k +: 8] = b[4*i + k];
            end
            exp_q.push_back({AW'(i % DEPTH), w});
        end
        exp_ovf    = (n_words >= DEPTH);
        start_done = done_cnt;
        wr_log.delete();
        sel_i = 1'b1;
        tick(4);
        check("core_rst_on_sel", core_rst_o, 1'b1);
    endtask

    task automatic session_end(input bit abort);
        int n;
        if (!abort) begin
            sel_i = 1'b0;
            n = 0;
            while (done_cnt == start_done && n < 60) begin
                tick(1);
                n++;
            end
            check("done_pulse_count", done_cnt - start_done, 1);
            tick(2);
        end else begin
            jtag_reset_i = 1'b1;
            tick(3);
            sel_i = 1'b0;
            tick(10);
            jtag_reset_i = 1'b0;
            tick(4);
            check("no_done_on_abort", done_cnt - start_done, 0);
        end
        check("ack_idle", ack_o, 1'b0);
        check("core_rst_released", core_rst_o, 1'b0);
        check("overflow", overflow_o, exp_ovf);
        check("all_writes_seen", exp_q.size(), 0);
    endtask

    task automatic run_session(input byte_q_t b, input bit abort, input int hold);
        session_begin(b, abort);
        foreach (b[i]) send_byte(b[i], hold);
        session_end(abort);
    endtask

    function automatic logic [AW+31:0] log_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return '1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        byte_q_t b;
        int      n;
        int      bad;

        tick(3);
        check("reset_ack", ack_o, 1'b0);
        check("reset_we", mem_we_o, 1'b0);
        check("reset_core_rst", core_rst_o, 1'b0);
        check("reset_done", done_o, 1'b0);
        check("reset_ovf", overflow_o, 1'b0);
        check("reset_addr_data", {mem_addr_o, mem_data_o}, '0);
        rst_i = 1'b0;
        tick(3);

        // Eight bytes: two full words.
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_session(b, 1'b0, 1);
        check("s8_write_count", wr_log.size(), 2);
        check("s8_word0", log_at(0), {2'd0, 32'h44332211});
        check("s8_word1", log_at(1), {2'd1, 32'h88776655});

        // Five bytes: one full word plus a zero-padded flush.
        b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_session(b, 1'b0, 0);
        check("p5_write_count", wr_log.size(), 2);
        check("p5_word0", log_at(0), {2'd0, 32'hA3A2A1A0});
        check("p5_flush", log_at(1), {2'd1, 32'h000000A4});

        // Long word_rdy: ack held, released SS+1 cycles after the fall, one byte.
        b = '{8'h5A};
        session_begin(b, 1'b0);
        data_i     = 8'h5A;
        word_rdy_i = 1'b1;
        wait_ack(1'b1, "hs_ack_rise");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ack_o !== 1'b1) bad++;
        end
        check("hs_ack_held", bad, 0);
        word_rdy_i = 1'b0;
        n = 0;
        while (ack_o === 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("hs_release_latency", n, SS + 1);
        session_end(1'b0);
        check("hs_write_count", wr_log.size(), 1);
        check("hs_word0", log_at(0), {2'd0, 32'h0000005A});

        // Abort after six bytes: only the first full word lands.
        b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        run_session(b, 1'b1, 1);
        check("ab_write_count", wr_log.size(), 1);
        check("ab_word0", log_at(0), {2'd0, 32'hC3C2C1C0});

        // Twenty bytes: five words wrap the four-word space.
        b = {};
        for (int i = 0; i < 20; i++) b.push_back(8'(i + 1));
        run_session(b, 1'b0, 0);
        check("wr_write_count", wr_log.size(), 5);
        check("wr_addr0", log_at(0), {2'd0, 32'h04030201});
        check("wr_addr3", log_at(3), {2'd3, 32'h100F0E0D});
        check("wr_wrapped", log_at(4), {2'd0, 32'h14131211});
        check("wr_ovf_idle", overflow_o, 1'b1);

        // Asynchronous reset in the middle of a handshake.
        sel_i = 1'b1;
        tick(4);
        data_i     = 8'hEE;
        word_rdy_i = 1'b1;
        wait_ack(1'b1, "rst_ack_rise");
        tick(1);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_ack", ack_o, 1'b0);
        check("async_rst_core_rst", core_rst_o, 1'b0);
        check("async_rst_ovf", overflow_o, 1'b0);
        check("async_rst_we_done", {mem_we_o, done_o}, 2'b00);
        check("async_rst_addr_data", {mem_addr_o, mem_data_o}, '0);
        word_rdy_i = 1'b0;
        sel_i      = 1'b0;
        tick(3);
        rst_i = 1'b0;
        tick(4);
        check("post_rst_idle", {ack_o, core_rst_o}, 2'b00);

        // Random sessions.
        for (int s = 0; s < 10; s++) begin
            b = {};
            n = $urandom_range(0, 13);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
            run_session(b, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            tick($urandom_range(1, 6));
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
